// File: rtl/elevator_controller.sv
// elevator_controller: N-floor SCAN elevator with latched calls,
// door/travel timers, emergency stop and overweight door hold.
module elevator_controller #(
    parameter int FLOORS       = 3,
    parameter int DOOR_TICKS   = 3,
    parameter int TRAVEL_TICKS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] floor_buttons,
    input  logic              sos_flip,
    input  logic              weight_sensor_flip,
    output logic [FLOORS-1:0] floor_leds,
    output logic [FLOORS-1:0] request_leds,
    output logic              door_status_led,
    output logic              moving_up,
    output logic              moving_down,
    output logic              emergency_led,
    output logic              weight_limit_exceeded_led
);

    localparam int FW = ($clog2(FLOORS) > 1) ? $clog2(FLOORS) : 1;
    localparam int TW = $clog2(TRAVEL_TICKS) + 1;
    localparam int DW = $clog2(DOOR_TICKS) + 1;

    localparam logic [TW-1:0]     TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0]     DOOR_LAST   = DW'(DOOR_TICKS - 1);
    localparam logic [FW-1:0]     TOP         = FW'(FLOORS - 1);
    localparam logic [FLOORS-1:0] ONE         = FLOORS'(1);

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DOOR_OPEN,
        EMERGENCY
    } state_t;

    state_t            state, state_n;
    logic [FW-1:0]     floor, floor_n;
    logic [FLOORS-1:0] req, req_n;
    logic              dir_up, dir_up_n;
    logic [TW-1:0]     travel_cnt, travel_cnt_n;
    logic [DW-1:0]     door_cnt, door_cnt_n;
    logic              weight, weight_n;
    logic              above, below, hold;

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (req[i] && i > int'(floor)) above = 1'b1;
            if (req[i] && i < int'(floor)) below = 1'b1;
        end
    end

    always_comb begin
        state_n      = state;
        floor_n      = floor;
        req_n        = req;
        dir_up_n     = dir_up;
        travel_cnt_n = travel_cnt;
        door_cnt_n   = door_cnt;
        weight_n     = weight;
        // a sensor trip on the expiry edge must still keep the door open
        hold = weight | (state == DOOR_OPEN && weight_sensor_flip);

        if (state != EMERGENCY) req_n = req | floor_buttons;

        if (state == DOOR_OPEN && weight_sensor_flip)
            weight_n = 1'b1;
        else if (!weight_sensor_flip && |floor_buttons)
            weight_n = 1'b0;

        if (sos_flip) begin
            state_n      = EMERGENCY;
            travel_cnt_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req[floor]) begin
                        state_n      = DOOR_OPEN;
                        req_n[floor] = 1'b0;
                        door_cnt_n   = DOOR_LAST;
                    end else if (above && (dir_up || !below)) begin
                        state_n      = MOVING;
                        dir_up_n     = 1'b1;
                        travel_cnt_n = '0;
                    end else if (below) begin
                        state_n      = MOVING;
                        dir_up_n     = 1'b0;
                        travel_cnt_n = '0;
                    end
                end
                MOVING: begin
                    if (travel_cnt == TRAVEL_LAST) begin
                        travel_cnt_n = '0;
                        floor_n = dir_up ? floor + 1'b1 : floor - 1'b1;
                        if (req_n[floor_n]) begin
                            state_n        = DOOR_OPEN;
                            req_n[floor_n] = 1'b0;
                            door_cnt_n     = DOOR_LAST;
                        end else if (dir_up ? (floor_n == TOP)
                                            : (floor_n == '0)) begin
                            state_n = IDLE;
                        end
                    end else begin
                        travel_cnt_n = travel_cnt + 1'b1;
                    end
                end
                DOOR_OPEN: begin
                    if (floor_buttons[floor]) begin
                        req_n[floor] = 1'b0;
                        door_cnt_n   = DOOR_LAST;
                    end else if (door_cnt != '0) begin
                        door_cnt_n = door_cnt - 1'b1;
                    end else if (!hold) begin
                        state_n = IDLE;
                    end
                end
                EMERGENCY: begin
                    state_n      = DOOR_OPEN;
                    req_n[floor] = 1'b0;
                    door_cnt_n   = DOOR_LAST;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            floor           <= '0;
            req             <= '0;
            dir_up          <= 1'b1;
            travel_cnt      <= '0;
            door_cnt        <= '0;
            weight          <= 1'b0;
            floor_leds      <= ONE;
            door_status_led <= 1'b0;
            moving_up       <= 1'b0;
            moving_down     <= 1'b0;
            emergency_led   <= 1'b0;
        end else begin
            state           <= state_n;
            floor           <= floor_n;
            req             <= req_n;
            dir_up          <= dir_up_n;
            travel_cnt      <= travel_cnt_n;
            door_cnt        <= door_cnt_n;
            weight          <= weight_n;
            floor_leds      <= ONE << floor_n;
            door_status_led <= (state_n == DOOR_OPEN);
            moving_up       <= (state_n == MOVING) && dir_up_n;
            moving_down     <= (state_n == MOVING) && !dir_up_n;
            emergency_led   <= (state_n == EMERGENCY);
        end
    end

    assign request_leds              = req;
    assign weight_limit_exceeded_led = weight;

    floor_in_range: assert property (
        @(posedge clk) disable iff (!rst_n) int'(floor) < FLOORS);

    one_direction: assert property (
        @(posedge clk) disable iff (!rst_n) !(moving_up && moving_down));

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: scripted vector table, randomized run
// against a behavioural model, and an 8-floor travel regression.
module tb_elevator_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn = '0;
    logic       sos = 1'b0;
    logic       wt = 1'b0;
    logic [2:0] fl, rq;
    logic       dr, up, dn, em, wl;

    logic [7:0] btn8 = '0;
    logic [7:0] fl8, rq8;
    logic       dr8, up8, dn8, em8, wl8;

    logic [10:0] got;
    assign got = {fl, rq, dr, up, dn, em, wl};

    always #5 clk = ~clk;

    elevator_controller #(
        .FLOORS(3), .DOOR_TICKS(3), .TRAVEL_TICKS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .floor_buttons(btn),
        .sos_flip(sos), .weight_sensor_flip(wt),
        .floor_leds(fl), .request_leds(rq),
        .door_status_led(dr), .moving_up(up), .moving_down(dn),
        .emergency_led(em), .weight_limit_exceeded_led(wl)
    );

    elevator_controller #(
        .FLOORS(8), .DOOR_TICKS(3), .TRAVEL_TICKS(2)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .floor_buttons(btn8),
        .sos_flip(1'b0), .weight_sensor_flip(1'b0),
        .floor_leds(fl8), .request_leds(rq8),
        .door_status_led(dr8), .moving_up(up8), .moving_down(dn8),
        .emergency_led(em8), .weight_limit_exceeded_led(wl8)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        bit        rs;
        bit [2:0]  b;
        bit        s;
        bit        w;
        bit [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rs, bit [2:0] b, bit s, bit w,
                                bit [2:0] efl, bit [2:0] erq, bit edr,
                                bit eup, bit edn, bit eem, bit ewl);
        vec_t v;
        v.rs = rs; v.b = b; v.s = s; v.w = w;
        v.exp = {efl, erq, edr, eup, edn, eem, ewl};
        tbl.push_back(v);
    endfunction

    // behavioural model: one call per clock edge
    localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2, M_EMG = 3;
    localparam int DOOR_T = 3, TRAVEL_T = 2;

    int       m_mode, m_floor, m_elapsed, m_door_left;
    bit [2:0] m_req;
    bit       m_up, m_wt;

    task automatic model_reset();
        m_mode = M_IDLE; m_floor = 0; m_elapsed = 0; m_door_left = 0;
        m_req = '0; m_up = 1'b1; m_wt = 1'b0;
    endtask

    task automatic model_open(input int f);
        m_mode = M_DOOR;
        m_req[f] = 1'b0;
        m_door_left = DOOR_T;
    endtask

    task automatic model_step(input bit [2:0] b, input bit s, input bit w);
        bit [2:0] old_req;
        bit hold, ab, be;
        old_req = m_req;
        hold = m_wt || (m_mode == M_DOOR && w);
        if (m_mode == M_DOOR && w) m_wt = 1'b1;
        else if (!w && b != 0) m_wt = 1'b0;
        if (m_mode != M_EMG) m_req = m_req | b;
        ab = 1'b0; be = 1'b0;
        for (int f = 0; f < 3; f++)
            if (old_req[f]) begin
                if (f > m_floor) ab = 1'b1;
                if (f < m_floor) be = 1'b1;
            end
        if (s) begin
            m_mode = M_EMG;
            m_elapsed = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (old_req[m_floor]) model_open(m_floor);
                    else if (ab && (m_up || !be)) begin
                        m_mode = M_MOVE; m_up = 1'b1; m_elapsed = 0;
                    end else if (be) begin
                        m_mode = M_MOVE; m_up = 1'b0; m_elapsed = 0;
                    end
                end
                M_MOVE: begin
                    m_elapsed++;
                    if (m_elapsed == TRAVEL_T) begin
                        m_elapsed = 0;
                        m_floor = m_up ? m_floor + 1 : m_floor - 1;
                        if (m_req[m_floor]) model_open(m_floor);
                    end
                end
                M_DOOR: begin
                    if (b[m_floor]) begin
                        m_req[m_floor] = 1'b0;
                        m_door_left = DOOR_T;
                    end else if (m_door_left > 1) m_door_left--;
                    else if (!hold) m_mode = M_IDLE;
                end
                default: model_open(m_floor);
            endcase
        end
    endtask

    function automatic logic [10:0] model_out();
        logic [2:0] f1;
        f1 = 3'b001 << m_floor;
        return {f1, m_req, m_mode == M_DOOR,
                m_mode == M_MOVE && m_up, m_mode == M_MOVE && !m_up,
                m_mode == M_EMG, m_wt};
    endfunction

    initial begin
        int mv;
        bit sos_on;

        // press 2 from floor 0
        add(0, 3'b100, 0, 0, 3'b001, 3'b100, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b100, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b100, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b100, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b100, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b100, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b100, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b100, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b100, 3'b000, 0, 0, 0, 0, 0);
        add(1, 3'b000, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0, 0);
        // go to floor 1 (last_dir up)
        add(0, 3'b010, 0, 0, 3'b001, 3'b010, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b010, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b010, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 0, 0, 0, 0, 0);
        // floors 0 and 2 together: up first, then down
        add(0, 3'b101, 0, 0, 3'b010, 3'b101, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b101, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b101, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b100, 3'b001, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b100, 3'b001, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b100, 3'b001, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b100, 3'b001, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b100, 3'b001, 0, 0, 1, 0, 0);
        add(0, 3'b000, 0, 0, 3'b100, 3'b001, 0, 0, 1, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b001, 0, 0, 1, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b001, 0, 0, 1, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0, 0);
        // SOS one cycle into travel 0->1
        add(0, 3'b010, 0, 0, 3'b001, 3'b010, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b010, 0, 1, 0, 0, 0);
        add(0, 3'b000, 1, 0, 3'b001, 3'b010, 0, 0, 0, 1, 0);
        add(0, 3'b000, 1, 0, 3'b001, 3'b010, 0, 0, 0, 1, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b010, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b010, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b010, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b010, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b010, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b010, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 0, 0, 0, 0, 0);
        // overweight hold at floor 1
        add(0, 3'b010, 0, 0, 3'b010, 3'b010, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 1, 3'b010, 3'b000, 1, 0, 0, 0, 1);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 1, 0, 0, 0, 1);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 1, 0, 0, 0, 1);
        add(0, 3'b000, 0, 0, 3'b010, 3'b000, 1, 0, 0, 0, 1);
        add(0, 3'b001, 0, 0, 3'b010, 3'b001, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b001, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b001, 0, 0, 1, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b001, 0, 0, 1, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b000, 1, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0, 0);
        // reset mid-travel
        add(0, 3'b100, 0, 0, 3'b001, 3'b100, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b100, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b001, 3'b100, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'b010, 3'b100, 0, 1, 0, 0, 0);
        add(1, 3'b000, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_vec", got, {3'b001, 3'b000, 5'b00000});
        check("reset_fl8", fl8, 8'h01);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            btn = tbl[i].b;
            sos = tbl[i].s;
            wt = tbl[i].w;
            rst_n = !tbl[i].rs;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        // randomized run against the model
        btn = '0; sos = 1'b0; wt = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        sos_on = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (sos_on) sos_on = ($urandom_range(0, 3) != 0);
            else sos_on = ($urandom_range(0, 59) == 0);
            sos = sos_on;
            wt = ($urandom_range(0, 5) == 0);
            btn = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            @(posedge clk);
            model_step(btn, sos, wt);
            #1;
            check($sformatf("rand%0d", c), got, model_out());
        end

        // 8-floor run 0 -> 7
        btn = '0; sos = 1'b0; wt = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        btn8 = 8'h80;
        @(posedge clk);
        #1;
        btn8 = 8'h00;
        check("f8_req", rq8, 8'h80);
        mv = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (up8) mv++;
            if (fl8 == 8'h80) break;
        end
        check("f8_travel", mv, 14);
        check("f8_floor", fl8, 8'h80);
        check("f8_door", dr8, 1'b1);
        check("f8_clear", rq8, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
